// File: rtl/cpu_pkg.sv
// Shared types for the 16-bit CPU front end: immediate-format select,
// opcode map, IF/ID buffer states and the decoded packet held per entry.
package cpu_pkg;

   localparam int unsigned CPU_PC_W    = 16;
   localparam int unsigned CPU_INSTR_W = 16;

   // Immediate format driven into the sign extender.
   typedef enum logic [1:0] {
      NONE      = 2'b00,
      FOURBIT   = 2'b01,
      EIGHTBIT  = 2'b10,
      TWELVEBIT = 2'b11
   } sel_t;

   // Opcodes live in instr[15:12].
   typedef enum logic [3:0] {
      OP_RTYPE = 4'b0000,
      OP_BLT   = 4'b0100,
      OP_BGT   = 4'b0101,
      OP_BEQ   = 4'b0110,
      OP_LW    = 4'b1000,
      OP_SW    = 4'b1011,
      OP_JMP   = 4'b1100,
      OP_HALT  = 4'b1111
   } opcode_t;

   // Occupancy of the two-entry skid buffer.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b10
   } state_t;

   // One buffered entry: raw word plus the fields decoded on entry.
   typedef struct packed {
      logic [CPU_INSTR_W-1:0] instr;
      logic [CPU_PC_W-1:0]    pc;
      sel_t                   offset_sel;
      logic                   illegal;
      logic                   is_halt;
   } packet_t;

   localparam packet_t PKT_RESET = '{
      instr:      '0,
      pc:         '0,
      offset_sel: NONE,
      illegal:    1'b0,
      is_halt:    1'b0
   };

endpackage

// File: rtl/if_id_stage_instr_decode.sv
// Combinational opcode decoder: immediate format, illegal and HALT flags.
// Used on the incoming word so every buffered entry carries its decode.
module instr_decode
   import cpu_pkg::*;
(
   input  logic [3:0] opcode_i,
   output sel_t       offset_sel_o,
   output logic       illegal_o,
   output logic       is_halt_o
);

   // Map the opcode to its immediate format; anything unlisted is illegal.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      offset_sel_o = NONE;
      illegal_o    = 1'b0;
      is_halt_o    = 1'b0;
      case (opcode_i)
         OP_RTYPE:         offset_sel_o = NONE;
         OP_LW, OP_SW:     offset_sel_o = FOURBIT;
         OP_BLT, OP_BGT,
         OP_BEQ:           offset_sel_o = EIGHTBIT;
         OP_JMP:           offset_sel_o = TWELVEBIT;
         OP_HALT:          is_halt_o    = 1'b1;
         default:          illegal_o    = 1'b1;
      endcase
   end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: a two-entry skid buffer between fetch and execute.
// The main entry always holds the oldest packet and drives the outputs; the
// skid entry absorbs one extra word so in_ready can be a pure register.
module if_id_stage
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W    = CPU_PC_W,
   parameter int unsigned INSTR_W = CPU_INSTR_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output sel_t               offset_sel,
   output logic [11:0]        imm_field,
   output logic [3:0]         rd_addr,
   output logic [3:0]         rs_addr,
   output logic               illegal,
   output logic               is_halt
);

   state_t  state_q, state_d;
   packet_t main_q, main_d;
   packet_t skid_q, skid_d;
   logic    in_ready_q, in_ready_d;
   logic    halt_seen_q, halt_seen_d;

   sel_t    dec_sel;
   logic    dec_illegal;
   logic    dec_halt;
   packet_t dec_pkt;
   logic    acc;
   logic    pop;

   instr_decode u_decode (
      .opcode_i     (in_instr[15:12]),
      .offset_sel_o (dec_sel),
      .illegal_o    (dec_illegal),
      .is_halt_o    (dec_halt)
   );

   // Bundle the incoming word with its decode so it can be stored as one entry.
   always_comb begin
      dec_pkt.instr      = in_instr;
      dec_pkt.pc         = in_pc;
      dec_pkt.offset_sel = dec_sel;
      dec_pkt.illegal    = dec_illegal;
      dec_pkt.is_halt    = dec_halt;
   end

   assign acc = in_valid & in_ready_q;
   assign pop = out_valid & out_ready;

   // Occupancy FSM and entry movement; flush overrides everything else.
   always_comb begin
      state_d     = state_q;
      main_d      = main_q;
      skid_d      = skid_q;
      halt_seen_d = halt_seen_q;
      if (flush) begin
         state_d     = EMPTY;
         halt_seen_d = 1'b0;
      end else begin
         if (acc && dec_pkt.is_halt) begin
            halt_seen_d = 1'b1;
         end
         case (state_q)
            EMPTY: begin
               if (acc) begin
                  main_d  = dec_pkt;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (acc && !pop) begin
                  skid_d  = dec_pkt;
                  state_d = TWO;
               end else if (acc && pop) begin
                  main_d  = dec_pkt;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               // in_ready is low here, so only a pop can move things.
               if (pop) begin
                  main_d  = skid_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
      // Computed from next state so the registered ready is exact, not late.
      in_ready_d = (state_d != TWO) && !halt_seen_d;
   end

   // Control state and the output-facing main entry, with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b0;
         halt_seen_q <= 1'b0;
         main_q      <= PKT_RESET;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         halt_seen_q <= halt_seen_d;
         main_q      <= main_d;
      end
   end

   // Skid data register.
   always_ff @(posedge clk) begin
      // NOTE: the skid entry is deliberately not reset: it is only ever read
      // when state says it is occupied, so its contents after reset are moot.
      skid_q <= skid_d;
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = (state_q != EMPTY);
   assign out_instr  = main_q.instr;
   assign out_pc     = main_q.pc;
   assign offset_sel = main_q.offset_sel;
   assign imm_field  = main_q.instr[11:0];
   assign rd_addr    = main_q.instr[11:8];
   assign rs_addr    = main_q.instr[7:4];
   assign illegal    = main_q.illegal;
   assign is_halt    = main_q.is_halt;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus a random
// stream; a negedge monitor scores every delivered packet against a queue.
module tb_if_id_stage;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic [15:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_instr;
   logic [15:0] out_pc;
   sel_t        offset_sel;
   logic [11:0] imm_field;
   logic [3:0]  rd_addr;
   logic [3:0]  rs_addr;
   logic        illegal;
   logic        is_halt;

   int tests_run = 0;
   int tests_failed = 0;

   packet_t exp_q[$];
   packet_t cur_exp;
   packet_t e;
   logic    prev_hold = 1'b0;
   logic [31:0] snap_data;
   logic [16:0] snap_ctrl;

   if_id_stage #(.PC_W(16), .INSTR_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .in_pc      (in_pc),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_pc     (out_pc),
      .offset_sel (offset_sel),
      .imm_field  (imm_field),
      .rd_addr    (rd_addr),
      .rs_addr    (rs_addr),
      .illegal    (illegal),
      .is_halt    (is_halt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic packet_t mk(input logic [15:0] w, input logic [15:0] pc,
                                  input sel_t sel, input logic ill, input logic halt);
      packet_t p;
      p.instr = w; p.pc = pc; p.offset_sel = sel; p.illegal = ill; p.is_halt = halt;
      return p;
   endfunction

   // Reference decode table for the random phase.
   function automatic packet_t ref_pkt(input logic [15:0] w, input logic [15:0] pc);
      packet_t p;
      p = mk(w, pc, NONE, 1'b0, 1'b0);
      case (w[15:12])
         4'h0:             p.offset_sel = NONE;
         4'h8, 4'hB:       p.offset_sel = FOURBIT;
         4'h4, 4'h5, 4'h6: p.offset_sel = EIGHTBIT;
         4'hC:             p.offset_sel = TWELVEBIT;
         4'hF:             p.is_halt = 1'b1;
         default:          p.illegal = 1'b1;
      endcase
      return p;
   endfunction

   // Monitor/scoreboard: handshakes are judged at negedge, where the values
   // seen are exactly those the next rising edge will sample.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_data", {out_instr, out_pc}, snap_data);
            check("hold_ctrl", {out_valid, offset_sel, illegal, is_halt, imm_field}, snap_ctrl);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out_valid", {31'b0, out_valid}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("pop_instr",   out_instr,  e.instr);
               check("pop_pc",      out_pc,     e.pc);
               check("pop_sel",     offset_sel, e.offset_sel);
               check("pop_imm",     imm_field,  e.instr[11:0]);
               check("pop_rd",      rd_addr,    e.instr[11:8]);
               check("pop_rs",      rs_addr,    e.instr[7:4]);
               check("pop_illegal", illegal,    e.illegal);
               check("pop_halt",    is_halt,    e.is_halt);
            end
         end
         if (flush) exp_q.delete();
         else if (in_valid && in_ready) exp_q.push_back(cur_exp);
         prev_hold = out_valid && !out_ready && !flush;
         snap_data = {out_instr, out_pc};
         snap_ctrl = {out_valid, offset_sel, illegal, is_halt, imm_field};
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic offer(input logic [15:0] w, input logic [15:0] pc, input packet_t exp);
      in_instr = w; in_pc = pc; cur_exp = exp; in_valid = 1'b1;
   endtask

   task automatic wait_accept(input string name);
      bit done = 1'b0;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         step();
      end
      if (!done) check({name, "_accept_timeout"}, {31'b0, in_ready}, 32'd1);
   endtask

   task automatic send(input string name, input logic [15:0] w, input logic [15:0] pc, input packet_t exp);
      offer(w, pc, exp);
      wait_accept(name);
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      bit done = 1'b0;
      for (int n = 0; n < 60 && !done; n++) begin
         step();
         if (exp_q.size() == 0 && !out_valid) done = 1'b1;
      end
      check({name, "_drain_left"}, exp_q.size(), 32'd0);
   endtask

   task automatic check_reset_outputs(input string name);
      @(negedge clk);
      check({name, "_out_valid"}, {31'b0, out_valid}, 32'd0);
      check({name, "_in_ready"},  {31'b0, in_ready},  32'd0);
      check({name, "_instr"},     out_instr,  32'd0);
      check({name, "_pc"},        out_pc,     32'd0);
      check({name, "_sel"},       offset_sel, NONE);
      check({name, "_imm"},       imm_field,  32'd0);
      check({name, "_rd_rs"},     {rd_addr, rs_addr}, 32'd0);
      check({name, "_illegal"},   {31'b0, illegal},   32'd0);
      check({name, "_halt"},      {31'b0, is_halt},   32'd0);
   endtask

   // Global time limit so the bench can never hang.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
      flush = 1'b0; out_ready = 1'b1; cur_exp = PKT_RESET;

      // 1: reset values, release, then LW with one-cycle latency.
      repeat (3) step();
      check_reset_outputs("t1_reset");
      rst_n = 1'b1;
      step();
      @(negedge clk);
      check("t1_in_ready_after_release", {31'b0, in_ready}, 32'd1);
      step();
      send("t1_lw", 16'h8A53, 16'h0010, mk(16'h8A53, 16'h0010, FOURBIT, 1'b0, 1'b0));
      check("t1_latency_out_valid", {31'b0, out_valid}, 32'd1);
      drain("t1");

      // 2: back-pressure fills both entries; order preserved on release.
      out_ready = 1'b0;
      send("t2_a", 16'h0123, 16'h0020, mk(16'h0123, 16'h0020, NONE,     1'b0, 1'b0));
      send("t2_b", 16'h6F80, 16'h0022, mk(16'h6F80, 16'h0022, EIGHTBIT, 1'b0, 1'b0));
      offer(16'hC7FF, 16'h0024, mk(16'hC7FF, 16'h0024, TWELVEBIT, 1'b0, 1'b0));
      @(negedge clk);
      check("t2_in_ready_full", {31'b0, in_ready}, 32'd0);
      step(); step();
      @(negedge clk);
      check("t2_in_ready_still_full", {31'b0, in_ready}, 32'd0);
      check("t2_head_is_first", out_instr, 32'h0123);
      out_ready = 1'b1;
      wait_accept("t2_c");
      in_valid = 1'b0;
      drain("t2");

      // 3a: flush in ONE with a same-cycle acceptance discards both.
      out_ready = 1'b0;
      send("t3_a", 16'hB123, 16'h0030, mk(16'hB123, 16'h0030, FOURBIT, 1'b0, 1'b0));
      offer(16'h5A5A, 16'h0032, mk(16'h5A5A, 16'h0032, EIGHTBIT, 1'b0, 1'b0));
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("t3a_out_valid_after_flush", {31'b0, out_valid}, 32'd0);
      check("t3a_in_ready_after_flush",  {31'b0, in_ready},  32'd1);
      // 3b: flush in TWO with in_valid high.
      step();
      send("t3_b", 16'hB123, 16'h0034, mk(16'hB123, 16'h0034, FOURBIT,  1'b0, 1'b0));
      send("t3_c", 16'h4567, 16'h0036, mk(16'h4567, 16'h0036, EIGHTBIT, 1'b0, 1'b0));
      offer(16'h5555, 16'h0038, mk(16'h5555, 16'h0038, EIGHTBIT, 1'b0, 1'b0));
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("t3b_out_valid_after_flush", {31'b0, out_valid}, 32'd0);
      check("t3b_in_ready_after_flush",  {31'b0, in_ready},  32'd1);
      out_ready = 1'b1;
      repeat (4) step();
      @(negedge clk);
      check("t3b_nothing_emerges", {31'b0, out_valid}, 32'd0);
      step();

      // 4: HALT blocks intake until a flush.
      out_ready = 1'b0;
      send("t4_halt", 16'hF000, 16'h0040, mk(16'hF000, 16'h0040, NONE, 1'b0, 1'b1));
      offer(16'h0001, 16'h0042, mk(16'h0001, 16'h0042, NONE, 1'b0, 1'b0));
      @(negedge clk);
      check("t4_is_halt_out",     {31'b0, is_halt},  32'd1);
      check("t4_in_ready_halted", {31'b0, in_ready}, 32'd0);
      step();
      out_ready = 1'b1;
      repeat (3) step();
      @(negedge clk);
      check("t4_in_ready_after_pop", {31'b0, in_ready},  32'd0);
      check("t4_empty_after_pop",    {31'b0, out_valid}, 32'd0);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      check("t4_in_ready_after_flush", {31'b0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      drain("t4");

      // 5: illegal opcode, then reset while two entries are held.
      send("t5_illegal", 16'h3456, 16'h0050, mk(16'h3456, 16'h0050, NONE, 1'b1, 1'b0));
      drain("t5");
      out_ready = 1'b0;
      send("t5_a", 16'h0AAA, 16'h0060, mk(16'h0AAA, 16'h0060, NONE,    1'b0, 1'b0));
      send("t5_b", 16'h8123, 16'h0062, mk(16'h8123, 16'h0062, FOURBIT, 1'b0, 1'b0));
      rst_n = 1'b0;
      step();
      check_reset_outputs("t5_midreset");
      step();
      rst_n = 1'b1;
      step();
      @(negedge clk);
      check("t5_in_ready_after_release", {31'b0, in_ready}, 32'd1);
      step();

      // 6: random traffic with occasional flush; the monitor does the scoring.
      for (int c = 0; c < 10000; c++) begin
         logic [3:0]  op;
         logic [15:0] w;
         logic [15:0] pc;
         op = 4'($urandom_range(0, 15));
         if (op == 4'hF && $urandom_range(0, 7) != 0) op = 4'h8;
         w  = {op, 12'($urandom)};
         pc = 16'($urandom);
         in_instr  = w;
         in_pc     = pc;
         cur_exp   = ref_pkt(w, pc);
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         flush     = ($urandom_range(0, 31) == 0);
         step();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drain("t6");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
